// File: rtl/pt2262_tx_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// pt2262_pkg
// Shared definitions for the PT2262 transmit scheduler: the scheduler state
// encoding, the encoder address/data widths and the default repeat count and
// sync watchdog limit.
// -----------------------------------------------------------------------------
package pt2262_pkg;

    localparam int ADDR_W      = 8;       // encoder address pins A0..A7
    localparam int DATA_W      = 4;       // encoder data pins D0..D3
    localparam int REPEATS_DEF = 4;       // code words per grant
    localparam int TIMEOUT_DEF = 262143;  // clocks allowed between sync edges

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ALIGN,
        ST_SEND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pt2262_tx_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. The combinational one-hot grant picks the first active
// request at or after the priority pointer. When 'advance' is strobed with a
// non-empty request, the pointer moves to the index after the winner, so the
// winner becomes lowest priority for the next round. Index 0 has the highest
// priority after reset.
//
// Ports
//   clk      in   clock
//   reset    in   synchronous active-high reset (pointer -> 0)
//   req      in   N_REQ request vector
//   advance  in   commit the current grant and rotate priority
//   gnt      out  N_REQ one-hot grant (combinational), zero when req == 0
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] gnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [PW-1:0] idx;
    logic          found;

    // Scan from the pointer, wrapping, and take the first active request.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PW'((int'(ptr) + i) % N_REQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_nxt = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                ptr_nxt = PW'((i + 1) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/pt2262_tx_scheduler.sv
// -----------------------------------------------------------------------------
// pt2262_tx_scheduler
// Shares one PT2262 encoder between N_REQ requesters. A round-robin arbiter
// picks a requester, its address/float mask/data are captured into the encoder
// registers, the scheduler aligns to the encoder's code-word boundary (rising
// edge of enc_sync) and then lets REPEATS code words go out before releasing
// the grant. A watchdog ends the transfer with err=1 if the encoder stops
// producing sync edges for TIMEOUT clocks.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   req        in   N_REQ level requests, held until done
//   req_addr   in   N_REQ x 8 binary addresses
//   req_float  in   N_REQ x 8 float masks (1 = drive that address bit as z)
//   req_data   in   N_REQ x 4 data nibbles
//   gnt        out  one-hot grant, held for the whole transfer
//   done       out  one-cycle end-of-transfer pulse
//   err        out  valid with done: 1 = sync watchdog expired
//   busy       out  high whenever the scheduler is not idle
//   enc_sync   in   encoder sync; rising edge = code-word boundary
//   enc_A      out  encoder address (z on floated bits, all z when idle)
//   enc_D      out  encoder data (0 when idle)
// -----------------------------------------------------------------------------
module pt2262_tx_scheduler
    import pt2262_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int REPEATS = REPEATS_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr,
    input  logic [N_REQ-1:0][ADDR_W-1:0]  req_float,
    input  logic [N_REQ-1:0][DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]              gnt,
    output logic                          done,
    output logic                          err,
    output logic                          busy,
    input  logic                          enc_sync,
    output wire  [ADDR_W-1:0]             enc_A,
    output logic [DATA_W-1:0]             enc_D
);

    localparam int RW = (REPEATS > 0) ? $clog2(REPEATS + 1) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t            state;
    logic              enc_sync_p1;
    logic              sync_rise;
    logic [RW-1:0]     rep_cnt;
    logic [RW-1:0]     rep_inc;
    logic              rep_last;
    logic [TW-1:0]     wdog;
    logic              wdog_expired;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] float_r;

    logic [N_REQ-1:0]  arb_gnt;
    logic              arb_adv;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] sel_float;
    logic [DATA_W-1:0] sel_data;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (arb_adv),
        .gnt     (arb_gnt)
    );

    // The pointer rotates only when a grant is actually taken from IDLE.
    assign arb_adv = (state == ST_IDLE) && (|req);

    always_comb begin
        sel_addr  = '0;
        sel_float = '0;
        sel_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_addr  = req_addr[i];
                sel_float = req_float[i];
                sel_data  = req_data[i];
            end
        end
    end

    // Edge detect against the previous-cycle sync sample.
    assign sync_rise    = enc_sync && !enc_sync_p1;
    assign rep_inc      = rep_cnt + RW'(1);
    assign rep_last     = (rep_inc == RW'(REPEATS));
    // The counter reaches TIMEOUT on the same edge that enters DONE, so the
    // done pulse lands TIMEOUT clocks after the clear (sync edge or ALIGN entry).
    assign wdog_expired = (wdog == TW'(TIMEOUT - 1));

    // Floated bits release the pin; idle keeps every float bit set.
    for (genvar b = 0; b < ADDR_W; b++) begin : g_enc_a
        assign enc_A[b] = float_r[b] ? 1'bz : addr_r[b];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            gnt         <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
            enc_sync_p1 <= 1'b0;
            rep_cnt     <= '0;
            wdog        <= '0;
            addr_r      <= '0;
            float_r     <= '1;
            enc_D       <= '0;
        end else begin
            enc_sync_p1 <= enc_sync;
            done        <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        // Capture the winner now so the encoder registers are
                        // already stable during LOAD; later input changes are ignored.
                        gnt     <= arb_gnt;
                        addr_r  <= sel_addr;
                        float_r <= sel_float;
                        enc_D   <= sel_data;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        state   <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    wdog  <= '0;
                    state <= ST_ALIGN;
                end

                ST_ALIGN, ST_SEND: begin
                    // A sync edge on the expiry cycle still counts as a sync.
                    if (sync_rise) begin
                        wdog <= '0;
                        if (state == ST_ALIGN) begin
                            rep_cnt <= '0;
                            state   <= ST_SEND;
                        end else begin
                            rep_cnt <= rep_inc;
                            if (rep_last) begin
                                done  <= 1'b1;
                                err   <= 1'b0;
                                state <= ST_DONE;
                            end
                        end
                    end else if (wdog_expired) begin
                        wdog  <= wdog + TW'(1);
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        wdog <= wdog + TW'(1);
                    end
                end

                ST_DONE: begin
                    gnt     <= '0;
                    busy    <= 1'b0;
                    float_r <= '1;
                    enc_D   <= '0;
                    state   <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pt2262_tx_scheduler.md
PT2262_TX_SCHEDULER -- requirements
Module: pt2262_tx_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one codificador_pt2262 encoder.
REQ-002 Parameter REPEATS, default 4, code words sent per grant (range 1..15).
REQ-003 Parameter TIMEOUT, default 262143, max clocks allowed between encoder sync rising edges.
REQ-004 clk  input  1  system clock, 3 MHz; one clock, all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester level request, held until done.
REQ-007 req_addr  input  N_REQ x 8  per-requester binary address.
REQ-008 req_float  input  N_REQ x 8  per-requester float mask; bit=1 drives that address bit as z (trinary F).
REQ-009 req_data  input  N_REQ x 4  per-requester data nibble.
REQ-010 gnt  output  N_REQ  one-hot grant, held for whole transfer.
REQ-011 done  output  1  one-cycle pulse at transfer end.
REQ-012 err  output  1  valid with done; 1 = sync timeout.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 enc_sync  input  1  encoder sync output; rising edge marks a code-word boundary.
REQ-015 enc_A  output  8  encoder address, bits z where float mask set.
REQ-016 enc_D  output  4  encoder data.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, ALIGN, SEND, DONE.
REQ-018 IDLE: if any req bit high, round-robin arbiter picks one; gnt asserted next cycle; go LOAD.
REQ-019 Round-robin priority SHALL start after the last granted index; after reset index 0 has highest priority.
REQ-020 LOAD: latch the granted requester's addr, float and data into enc_A/enc_D registers; go ALIGN next cycle.
REQ-021 ALIGN: wait for first enc_sync rising edge (edge-detected via registered enc_sync); go SEND, repeat counter=0.
REQ-022 SEND: each enc_sync rising edge increments counter; when counter reaches REPEATS, go DONE.
REQ-023 Watchdog counter SHALL reset on each enc_sync rising edge and on entering ALIGN; reaching TIMEOUT in ALIGN or SEND goes DONE with err=1.
REQ-024 DONE: done=1 for exactly one cycle, err valid, gnt deasserted on the following cycle; return IDLE.
REQ-025 enc_A/enc_D SHALL stay constant from LOAD to DONE inclusive; requester inputs changing mid-transfer have no effect.
REQ-026 req dropped mid-transfer SHALL NOT abort; transfer completes normally.
REQ-027 In IDLE, enc_A=8'hzz and enc_D=4'h0.
REQ-028 Sync rising edge coincident with the timeout cycle SHALL count as a sync (no error).
REQ-029 Repeat and watchdog counters SHALL saturate-free wrap only via explicit clear; widths ceil(log2(REPEATS+1)) and ceil(log2(TIMEOUT+1)).

Reset
REQ-030 On reset: state IDLE, gnt=0, done=0, err=0, busy=0, enc_A all z, enc_D=0, counters 0, arbiter pointer to index 0.
REQ-031 Reset asserted mid-transfer SHALL return to IDLE on the next clock edge with no done pulse.

Structure
REQ-032 Package pt2262_pkg SHALL hold the state enum, address/data width constants (8, 4) and default REPEATS/TIMEOUT.
REQ-033 Round-robin arbitration SHALL be a sub-module rr_arbiter (req, advance strobe, one-hot gnt).

Verification (bench: REPEATS=2, TIMEOUT=64, stub drives enc_sync high 1 cycle every 20 cycles unless noted)
REQ-034 req=4'b0001, addr=8'hA5, float=8'h00, data=4'h9 -> gnt=0001, enc_A=8'hA5, enc_D=9 held; done after 2nd sync edge past alignment, err=0.
REQ-035 req=4'b1111 held continuously -> grants in order 0001,0010,0100,1000,0001; each done err=0.
REQ-036 float=8'h24, addr=8'h81 -> enc_A=8'b10z00z01 throughout transfer.
REQ-037 stub sync stopped after grant -> done with err=1 exactly 64 cycles after last sync edge (or ALIGN entry).
REQ-038 reset pulsed in SEND -> next cycle gnt=0, busy=0, no done; fresh req then granted to index 0.
REQ-039 req dropped and req_data changed during SEND -> enc_D unchanged, transfer completes with done.
